// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm
// Main/side intersection controller with a pedestrian walk phase and a night
// flash mode. Phase durations are counted in upstream timer ticks. Every lamp
// output comes straight from a flop. The next-state block below works out the
// next lamp values, so the lamps change on the same edge as the state.

module traffic_light_fsm #(
  parameter int GREEN_MAIN_TICKS = 10,
  parameter int GREEN_SIDE_TICKS = 6,
  parameter int YELLOW_TICKS     = 3,
  parameter int ALLRED_TICKS     = 1,
  parameter int WALK_TICKS       = 5,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  input  logic       night_mode,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic       ped_pending,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MG  = 3'd0,  // main green
    MY  = 3'd1,  // main yellow
    AR1 = 3'd2,  // all red, main -> side
    SG  = 3'd3,  // side green
    SY  = 3'd4,  // side yellow
    AR2 = 3'd5,  // all red, side -> main / walk
    PW  = 3'd6,  // pedestrian walk
    FL  = 3'd7   // night flash
  } state_t;

  // Lamp codes are {red, yellow, green}.
  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // A duration of 0 would never expire, so it is treated as 1 tick.
  function automatic logic [CNT_W-1:0] to_cnt(input int t);
    return (t <= 0) ? CNT_W'(1) : CNT_W'(t);
  endfunction

  // Phase length, in ticks, loaded into the counter when a state is entered.
  // FL ignores the counter because it is left by night_mode going low.
  function automatic logic [CNT_W-1:0] phase_len(input state_t s);
    case (s)
      MG:      return to_cnt(GREEN_MAIN_TICKS);
      MY, SY:  return to_cnt(YELLOW_TICKS);
      AR1, AR2: return to_cnt(ALLRED_TICKS);
      SG:      return to_cnt(GREEN_SIDE_TICKS);
      PW:      return to_cnt(WALK_TICKS);
      default: return CNT_W'(1);
    endcase
  endfunction

  state_t           state, state_nx;
  logic [CNT_W-1:0] rem, rem_nx;
  logic             flash, flash_nx;   // 1 = flash lamps lit
  logic             pend_nx;
  logic [2:0]       main_nx, side_nx;
  logic             walk_nx;
  logic             last;

  assign last      = (rem == CNT_W'(1));
  assign state_dbg = state;

  // Next state, phase counter, flash phase and pedestrian latch.
  always_comb begin
    // NOTE: every signal gets a default before any branch. This keeps the
    // block purely combinational, so no latch is inferred.
    state_nx = state;
    rem_nx   = rem;
    flash_nx = flash;
    pend_nx  = ped_pending;

    // A request is latched on any clock except during the walk it would be served by.
    if (ped_req && state != PW) pend_nx = 1'b1;

    if (tick) begin
      case (state)
        MG:  if (night_mode || last) state_nx = MY;
        MY:  if (last) state_nx = AR1;
        AR1: if (last) state_nx = SG;
        SG:  if (night_mode || last) state_nx = SY;
        SY:  if (last) state_nx = AR2;
        // The walk decision uses the pending value held before this edge.
        AR2: if (last) state_nx = night_mode ? FL : (ped_pending ? PW : MG);
        PW:  if (last) state_nx = night_mode ? FL : MG;
        FL:  if (!night_mode) state_nx = AR2;
             else             flash_nx = ~flash;
        default: state_nx = AR2;
      endcase

      if (state_nx != state) begin
        rem_nx   = phase_len(state_nx);
        flash_nx = 1'b1;
      end else if (state != FL) begin
        rem_nx = rem - CNT_W'(1);
      end
    end

    // Entering the walk serves the request. A press on this same edge is dropped.
    if (state_nx == PW && state != PW) pend_nx = 1'b0;
  end

  // Lamp decode from the next state, so the lamps can be registered.
  always_comb begin
    main_nx = LAMP_R;
    side_nx = LAMP_R;
    walk_nx = 1'b0;
    case (state_nx)
      MG: main_nx = LAMP_G;
      MY: main_nx = LAMP_Y;
      SG: side_nx = LAMP_G;
      SY: side_nx = LAMP_Y;
      PW: walk_nx = 1'b1;
      FL: begin
        main_nx = flash_nx ? LAMP_Y : LAMP_OFF;
        side_nx = flash_nx ? LAMP_R : LAMP_OFF;
      end
      default: ;
    endcase
  end

  // State and output registers. Reset starts in the AR2 clearance phase.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only. All flops then
    // update together, and readers in other blocks see the values from before the edge.
    if (rst) begin
      state       <= AR2;
      rem         <= to_cnt(ALLRED_TICKS);
      flash       <= 1'b1;
      ped_pending <= 1'b0;
      main_light  <= LAMP_R;
      side_light  <= LAMP_R;
      walk        <= 1'b0;
    end else begin
      state       <= state_nx;
      rem         <= rem_nx;
      flash       <= flash_nx;
      ped_pending <= pend_nx;
      main_light  <= main_nx;
      side_light  <= side_nx;
      walk        <= walk_nx;
    end
  end

endmodule
